// File: rtl/sum_it_up_pkg.sv
// Shared types and constants for the sum_it_up serial accumulator.
package sum_it_up_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sum_register.sv
// Accumulator storage: register with synchronous clear and load enable.
module sum_register
    import sum_it_up_pkg::*;
(
    input  logic              ck,
    input  logic              reset_l,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear wins over load so a go request always starts the run from zero.
    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sum_it_up.sv
// Serial 8-bit accumulator: go_l starts a run, nonzero bytes add into sum,
// a zero byte ends the run and done pulses for one cycle.
module sum_it_up
    import sum_it_up_pkg::*;
(
    input  logic              ck,
    input  logic              reset_l,
    input  logic              go_l,
    input  logic [DATA_W-1:0] inA,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic [1:0]        dbg_state
);

    // Protocol: go_l is a level sampled only in IDLE; inA is a byte stream sampled
    // every SUM cycle with 0 as terminator. There is no backpressure.
    state_t             state, state_next;
    logic               clr, en;
    logic               ina_zero;
    logic [DATA_W-1:0]  sum_next;

    assign ina_zero = (inA == '0);
    assign sum_next = sum + inA;

    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr        = 1'b0;
        en         = 1'b0;
        case (state)
            IDLE: begin
                if (!go_l) begin
                    clr        = 1'b1;
                    state_next = SUM;
                end
            end
            SUM: begin
                if (ina_zero) begin
                    state_next = DONE;
                end else begin
                    en = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign done      = (state == DONE);
    assign dbg_state = state;

    sum_register u_sum_register (
        .ck      (ck),
        .reset_l (reset_l),
        .clr     (clr),
        .en      (en),
        .d       (sum_next),
        .q       (sum)
    );

endmodule

// File: tb/tb_sum_it_up.sv
// Directed, table-driven bench for the sum_it_up serial accumulator.
module tb_sum_it_up;
    import sum_it_up_pkg::*;

    logic       ck;
    logic       reset_l;
    logic       go_l;
    logic [7:0] inA;
    logic       done;
    logic [7:0] sum;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       go_l;
        logic [7:0] ina;
        logic       exp_done;
        logic [7:0] exp_sum;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[$];

    sum_it_up dut (
        .ck        (ck),
        .reset_l   (reset_l),
        .go_l      (go_l),
        .inA       (inA),
        .done      (done),
        .sum       (sum),
        .dbg_state (dbg_state)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_done, input logic [7:0] e_sum,
                             input logic [1:0] e_state);
        check({tag, " done"},  {7'd0, done}, {7'd0, e_done});
        check({tag, " sum"},   sum, e_sum);
        check({tag, " state"}, {6'd0, dbg_state}, {6'd0, e_state});
    endtask

    // Drive inputs, take one posedge, then settle before the caller samples.
    task automatic step(input logic g, input logic [7:0] a);
        go_l = g;
        inA  = a;
        @(posedge ck);
        #1;
    endtask

    function automatic void add(input logic g, input logic [7:0] a, input logic e_done,
                                input logic [7:0] e_sum, input logic [1:0] e_state);
        vec_t v;
        v.go_l      = g;
        v.ina       = a;
        v.exp_done  = e_done;
        v.exp_sum   = e_sum;
        v.exp_state = e_state;
        vecs.push_back(v);
    endfunction

    initial begin
        // Each entry: inputs driven before a posedge, outputs expected after it.
        // Idle with go_l high
        add(1, 8'd55,  0, 8'd0,  IDLE);
        add(1, 8'd0,   0, 8'd0,  IDLE);
        // go cycle byte 4 ignored; then 4,4,0 -> 8
        add(0, 8'd4,   0, 8'd0,  SUM);
        add(1, 8'd4,   0, 8'd4,  SUM);
        add(1, 8'd4,   0, 8'd8,  SUM);
        add(1, 8'd0,   1, 8'd8,  DONE);
        add(0, 8'd0,   0, 8'd8,  IDLE);  // go_l low in DONE is ignored
        // back-to-back: go, then 3,3,3,0 -> 9
        add(0, 8'd7,   0, 8'd0,  SUM);
        add(1, 8'd3,   0, 8'd3,  SUM);
        add(1, 8'd3,   0, 8'd6,  SUM);
        add(1, 8'd3,   0, 8'd9,  SUM);
        add(1, 8'd0,   1, 8'd9,  DONE);
        add(1, 8'd0,   0, 8'd9,  IDLE);
        add(1, 8'd12,  0, 8'd9,  IDLE);  // sum holds in IDLE
        // empty run
        add(0, 8'd5,   0, 8'd0,  SUM);
        add(1, 8'd0,   1, 8'd0,  DONE);
        add(1, 8'd0,   0, 8'd0,  IDLE);
        // wrap: 200 + 100 = 44; go_l low mid-run does not restart
        add(0, 8'd0,   0, 8'd0,  SUM);
        add(1, 8'd200, 0, 8'd200, SUM);
        add(0, 8'd100, 0, 8'd44, SUM);
        add(1, 8'd0,   1, 8'd44, DONE);
        add(1, 8'd0,   0, 8'd44, IDLE);
        add(1, 8'd77,  0, 8'd44, IDLE);

        reset_l = 1'b0;
        go_l    = 1'b1;
        inA     = 8'd0;
        repeat (3) @(posedge ck);
        #1;
        check_all("reset held", 0, 8'd0, IDLE);
        @(negedge ck);
        reset_l = 1'b1;
        #1;
        check_all("reset released", 0, 8'd0, IDLE);

        foreach (vecs[i]) begin
            step(vecs[i].go_l, vecs[i].ina);
            check_all($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_sum,
                      vecs[i].exp_state);
        end

        // Reset mid-run: aborts at once, no done pulse afterwards.
        step(0, 8'd0);
        step(1, 8'd5);
        check_all("midrun before reset", 0, 8'd5, SUM);
        go_l    = 1'b0;
        inA     = 8'd6;
        #2;
        reset_l = 1'b0;
        #1;
        check_all("midrun async reset", 0, 8'd0, IDLE);
        @(posedge ck);
        #1;
        check_all("midrun reset hold", 0, 8'd0, IDLE);
        @(negedge ck);
        go_l    = 1'b1;
        inA     = 8'd0;
        reset_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1, 8'd0);
            check_all($sformatf("post reset %0d", k), 0, 8'd0, IDLE);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
